// File: rtl/toy_int_phy_freelist.sv
// Integer physical-register free list: circular FIFO of unmapped IDs feeding one staged ID per decode slot.
// Latency: consumed slot restaged at the next edge, releases refill a cycle later; no backpressure, overflow drops the cycle's pushes.
module toy_int_phy_freelist #(
    parameter int INST_DECODE_NUM  = 4,
    parameter int PHY_REG_NUM      = 64,
    parameter int PHY_REG_ID_WIDTH = 6,
    parameter int ARCH_REG_NUM     = 32,
    parameter int RELEASE_NUM      = 4
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    output logic [INST_DECODE_NUM-1:0]                        v_int_pre_allocate_vld,
    output logic [INST_DECODE_NUM-1:0][PHY_REG_ID_WIDTH-1:0]  v_int_pre_allocate_id,
    input  logic [INST_DECODE_NUM-1:0]                        v_int_pre_allocate_rdy,
    input  logic [INST_DECODE_NUM-1:0]                        v_int_pre_allocate_zero,
    input  logic [RELEASE_NUM-1:0]                            v_release_vld,
    input  logic [RELEASE_NUM-1:0][PHY_REG_ID_WIDTH-1:0]      v_release_id,
    output logic [$clog2(PHY_REG_NUM+1)-1:0]                  free_cnt,
    output logic                                              freelist_err
);

    localparam int PTR_W = PHY_REG_ID_WIDTH;
    localparam int CNT_W = $clog2(PHY_REG_NUM + 1);

    logic [PTR_W-1:0]                        fifo [PHY_REG_NUM];
    logic [PTR_W-1:0]                        head;
    logic [PTR_W-1:0]                        tail;
    logic [CNT_W-1:0]                        cnt;
    logic [INST_DECODE_NUM-1:0]              hold_vld;
    logic [INST_DECODE_NUM-1:0]              hold_vld_nxt;
    logic [INST_DECODE_NUM-1:0][PTR_W-1:0]   hold_id;
    logic [INST_DECODE_NUM-1:0][PTR_W-1:0]   hold_id_nxt;
    logic [INST_DECODE_NUM-1:0]              cons;
    logic [INST_DECODE_NUM-1:0]              refill;
    logic [CNT_W-1:0]                        npop;
    logic [CNT_W-1:0]                        npush;
    logic [CNT_W:0]                          cnt_sum;
    logic                                    ovf;
    logic                                    rel_zero;
    logic [RELEASE_NUM-1:0]                  push_ok;
    logic [RELEASE_NUM-1:0]                  wr_en;
    logic [RELEASE_NUM-1:0][PTR_W-1:0]       wr_idx;

    // Empty or consumed slots take FIFO entries in ascending slot order while stock lasts.
    always_comb begin
        cons         = hold_vld & v_int_pre_allocate_rdy & ~v_int_pre_allocate_zero;
        refill       = ~hold_vld | cons;
        hold_vld_nxt = hold_vld;
        hold_id_nxt  = hold_id;
        npop         = '0;
        for (int i = 0; i < INST_DECODE_NUM; i++) begin
            if (refill[i]) begin
                if (npop < cnt) begin
                    hold_vld_nxt[i] = 1'b1;
                    hold_id_nxt[i]  = fifo[head + PTR_W'(npop)];
                    npop            = npop + CNT_W'(1);
                end else begin
                    hold_vld_nxt[i] = 1'b0;
                end
            end
        end
    end

    // Valid non-zero releases are packed onto consecutive tail slots.
    always_comb begin
        push_ok  = '0;
        rel_zero = 1'b0;
        npush    = '0;
        wr_idx   = '0;
        for (int j = 0; j < RELEASE_NUM; j++) begin
            wr_idx[j] = tail + PTR_W'(npush);
            if (v_release_vld[j]) begin
                if (v_release_id[j] == '0) begin
                    rel_zero = 1'b1;
                end else begin
                    push_ok[j] = 1'b1;
                    npush      = npush + CNT_W'(1);
                end
            end
        end
        cnt_sum = {1'b0, cnt} - {1'b0, npop} + {1'b0, npush};
        ovf     = cnt_sum > (CNT_W+1)'(PHY_REG_NUM);
        wr_en   = ovf ? '0 : push_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PHY_REG_NUM; k++) begin
                fifo[k] <= (k < PHY_REG_NUM - ARCH_REG_NUM) ? PTR_W'(ARCH_REG_NUM + k) : '0;
            end
            head         <= '0;
            tail         <= PTR_W'(PHY_REG_NUM - ARCH_REG_NUM);
            cnt          <= CNT_W'(PHY_REG_NUM - ARCH_REG_NUM);
            hold_vld     <= '0;
            hold_id      <= '0;
            freelist_err <= 1'b0;
        end else begin
            for (int j = 0; j < RELEASE_NUM; j++) begin
                if (wr_en[j]) begin
                    fifo[wr_idx[j]] <= v_release_id[j];
                end
            end
            head     <= head + PTR_W'(npop);
            tail     <= tail + (ovf ? '0 : PTR_W'(npush));
            cnt      <= ovf ? (cnt - npop) : cnt_sum[CNT_W-1:0];
            hold_vld <= hold_vld_nxt;
            hold_id  <= hold_id_nxt;
            if (ovf || rel_zero) begin
                freelist_err <= 1'b1;
            end
        end
    end

    assign v_int_pre_allocate_vld = hold_vld;
    assign v_int_pre_allocate_id  = hold_id;
    assign free_cnt               = cnt;

endmodule
